dds_sweep_ctrl: RTL and testbench

Sequencer that drives the 32-bit phase increment of the DDS phase accumulator. It replaces a static preset lookup with programmable tone, linear sweep and triangle-sweep schedules. It steps the increment from a start value to a stop value at a fixed step size, holding each value for a programmable dwell. Updates can optionally be aligned to phase-accumulator wrap so that frequency changes are glitch-free.

---
 rtl/dds_ctrl_pkg.sv | 22 ++
 rtl/dds_step_alu.sv | 50 +++++
 rtl/dds_sweep_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the DDS phase-increment sweep controller.
package dds_ctrl_pkg;

    localparam int unsigned DDS_INC_W   = 32;
    localparam int unsigned DDS_DWELL_W = 16;

    // Schedule encodings carried on mode_i
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_FIXED  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_WAIT_WRAP
    } state_e;

endpackage

// File: rtl/dds_step_alu.sv
// Clamped one-step add/sub for the phase increment.
//   inc_i, step_i     : current increment and step size
//   lo_i, hi_i        : lower / upper clamp limits
//   dir_i             : 0 = step up toward hi_i, 1 = step down toward lo_i
//   nxt_o             : next increment, never beyond the limit in the step direction
//   hit_limit_o       : nxt_o sits exactly on that limit
module dds_step_alu
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned INC_W = DDS_INC_W
) (
    input  logic [INC_W-1:0] inc_i,
    input  logic [INC_W-1:0] step_i,
    input  logic [INC_W-1:0] lo_i,
    input  logic [INC_W-1:0] hi_i,
    input  logic             dir_i,
    output logic [INC_W-1:0] nxt_o,
    output logic             hit_limit_o
);

    // One extra bit so neither the sum nor the floor can wrap
    logic [INC_W:0] sum_c;
    logic [INC_W:0] floor_c;

    assign sum_c   = {1'b0, inc_i} + {1'b0, step_i};
    assign floor_c = {1'b0, lo_i} + {1'b0, step_i};

    always_comb begin
        nxt_o       = inc_i;
        hit_limit_o = 1'b0;
        if (!dir_i) begin
            if (sum_c >= {1'b0, hi_i}) begin
                nxt_o       = hi_i;
                hit_limit_o = 1'b1;
            end else begin
                nxt_o = sum_c[INC_W-1:0];
            end
        end else begin
            if ({1'b0, inc_i} < floor_c) begin
                nxt_o       = lo_i;
                hit_limit_o = 1'b1;
            end else begin
                nxt_o       = inc_i - step_i;
                // an exact landing on lo_i also leaves us at the bottom
                hit_limit_o = ({1'b0, inc_i} == floor_c);
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Phase-increment sequencer: fixed tone, single sweep, sawtooth and triangle
// schedules with per-value dwell and optional alignment to accumulator wrap.
//   clk_i, rst_i                  : clock, async active-high reset
//   start_i, abort_i              : schedule start (IDLE only) / terminate pulses
//   mode_i, start_inc_i, stop_inc_i, step_inc_i, dwell_i, sync_en_i : config, latched at start
//   acc_wrap_i                    : phase accumulator overflow strobe
//   inc_o, inc_valid_o            : phase increment and its change pulse
//   busy_o, done_o, dir_o, cfg_err_o : status
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned INC_W   = DDS_INC_W,
    parameter int unsigned DWELL_W = DDS_DWELL_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [1:0]         mode_i,
    input  logic [INC_W-1:0]   start_inc_i,
    input  logic [INC_W-1:0]   stop_inc_i,
    input  logic [INC_W-1:0]   step_inc_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               sync_en_i,
    input  logic               acc_wrap_i,
    output logic [INC_W-1:0]   inc_o,
    output logic               inc_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               dir_o,
    output logic               cfg_err_o
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [INC_W-1:0]   lo_q, lo_d, hi_q, hi_d, step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic               sync_q, sync_d;
    logic [INC_W-1:0]   inc_q, inc_d;
    logic               inc_valid_q, inc_valid_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               dir_q, dir_d, cfg_err_q, cfg_err_d;
    // inc_q currently equals the limit it was stepping toward
    logic               lim_q, lim_d;

    logic [DWELL_W-1:0] reload_c;
    logic               dir_eff_c;
    logic               do_upd_c;
    logic [INC_W-1:0]   alu_nxt_c;
    logic               alu_hit_c;

    // dwell of 0 behaves as 1
    assign reload_c  = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
    // triangle turns around on the same update that leaves a limit
    assign dir_eff_c = (mode_q == MODE_TRI && lim_q) ? ~dir_q : dir_q;

    dds_step_alu #(.INC_W(INC_W)) u_alu (
        .inc_i       (inc_q),
        .step_i      (step_q),
        .lo_i        (lo_q),
        .hi_i        (hi_q),
        .dir_i       (dir_eff_c),
        .nxt_o       (alu_nxt_c),
        .hit_limit_o (alu_hit_c)
    );

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_SINGLE;
            lo_q        <= '0;
            hi_q        <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            sync_q      <= 1'b0;
            cnt_q       <= '0;
            inc_q       <= '0;
            inc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dir_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
            lim_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            inc_q       <= inc_d;
            inc_valid_q <= inc_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dir_q       <= dir_d;
            cfg_err_q   <= cfg_err_d;
            lim_q       <= lim_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        sync_d      = sync_q;
        cnt_d       = cnt_q;
        inc_d       = inc_q;
        inc_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dir_d       = dir_q;
        cfg_err_d   = 1'b0;
        lim_d       = lim_q;
        do_upd_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    if (mode_i != MODE_FIXED &&
                        (step_inc_i == '0 || start_inc_i > stop_inc_i)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        mode_d  = mode_e'(mode_i);
                        lo_d    = start_inc_i;
                        hi_d    = stop_inc_i;
                        step_d  = step_inc_i;
                        dwell_d = dwell_i;
                        sync_d  = sync_en_i;
                        busy_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                inc_d       = lo_q;
                inc_valid_d = 1'b1;
                dir_d       = 1'b0;
                lim_d       = (lo_q == hi_q);
                cnt_d       = reload_c;
                if (mode_q == MODE_FIXED) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!sync_q || acc_wrap_i) begin
                    do_upd_c = 1'b1;
                end else begin
                    state_d = ST_WAIT_WRAP;
                end
            end
            ST_WAIT_WRAP: begin
                if (acc_wrap_i) begin
                    do_upd_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // End-of-dwell update
        if (do_upd_c) begin
            cnt_d   = reload_c;
            state_d = ST_DWELL;
            if (lim_q && !dir_q && mode_q == MODE_SINGLE) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else if (lim_q && !dir_q && mode_q == MODE_SAW) begin
                inc_d       = lo_q;
                inc_valid_d = (lo_q != inc_q);
                lim_d       = (lo_q == hi_q);
            end else begin
                inc_d       = alu_nxt_c;
                dir_d       = dir_eff_c;
                inc_valid_d = (alu_nxt_c != inc_q);
                lim_d       = alu_hit_c;
            end
        end

        // Abort overrides everything, including a same-cycle start
        if (abort_i) begin
            state_d     = ST_IDLE;
            inc_d       = '0;
            inc_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            dir_d       = 1'b0;
            cfg_err_d   = 1'b0;
            lim_d       = 1'b0;
        end
    end

    assign inc_o       = inc_q;
    assign inc_valid_o = inc_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dir_o       = dir_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of schedules with expected
// increment sequences fed through a scoreboard, plus hand-written corner cases.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic [31:0] start_inc_i = '0;
    logic [31:0] stop_inc_i = '0;
    logic [31:0] step_inc_i = '0;
    logic [15:0] dwell_i = '0;
    logic        sync_en_i = 1'b0;
    logic        acc_wrap_i = 1'b0;
    logic [31:0] inc_o;
    logic        inc_valid_o, busy_o, done_o, dir_o, cfg_err_o;

    dds_sweep_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .mode_i      (mode_i),
        .start_inc_i (start_inc_i),
        .stop_inc_i  (stop_inc_i),
        .step_inc_i  (step_inc_i),
        .dwell_i     (dwell_i),
        .sync_en_i   (sync_en_i),
        .acc_wrap_i  (acc_wrap_i),
        .inc_o       (inc_o),
        .inc_valid_o (inc_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dir_o       (dir_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk = ~clk;

    // mode, lo, hi, step, dwell, sync, n expected values, dir bitmask,
    // terminates with done, cycles from last value to done, hold per value (0 = unchecked)
    typedef struct {
        int unsigned mode, lo, hi, step, dwell, sync, n, dirs, term, done_gap, gap;
    } vec_t;
    typedef struct {
        logic [31:0] inc;
        logic        dir;
    } exp_t;

    vec_t        vec [8];
    int unsigned exp_tab [8][10];
    exp_t        sbq[$];

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    pulses, first_pc, last_pc, done_cnt, done_cyc, err_cnt;
    int    gap_chk = 0;
    bit    sync_chk = 1'b0;
    bit    wrap_en = 1'b0;
    logic  wrap_at_edge;
    string ctx = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h want %0h (cycle %0d)", ctx, name, act, exp, cyc);
        end
    endtask

    // Advance one clock, sample #1 after the edge, run the scoreboard monitor
    task automatic tick();
        exp_t e;
        @(posedge clk);
        wrap_at_edge = acc_wrap_i;
        #1;
        cyc++;
        if (inc_valid_o) begin
            pulses++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s/extra_inc_valid: got pulse with inc %0h, want none", ctx, inc_o);
            end else begin
                e = sbq.pop_front();
                check("inc", inc_o, e.inc);
                check("dir", 32'(dir_o), 32'(e.dir));
            end
            if (pulses == 1) begin
                first_pc = cyc;
            end else begin
                if (gap_chk != 0) check("hold", 32'(cyc - last_pc), 32'(gap_chk));
                if (sync_chk) check("wrap_align", 32'(wrap_at_edge), 32'd1);
            end
            last_pc = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cfg_err_o) err_cnt++;
        acc_wrap_i = wrap_en && (cyc % 5 == 4);
    endtask

    task automatic clear_mon();
        pulses   = 0;
        first_pc = 0;
        last_pc  = 0;
        done_cnt = 0;
        done_cyc = 0;
        err_cnt  = 0;
        sbq.delete();
    endtask

    task automatic drive_cfg(input vec_t v);
        mode_i      = 2'(v.mode);
        start_inc_i = v.lo;
        stop_inc_i  = v.hi;
        step_inc_i  = v.step;
        dwell_i     = 16'(v.dwell);
        sync_en_i   = 1'(v.sync);
    endtask

    task automatic push_exp(input logic [31:0] val, input logic d);
        exp_t e;
        e.inc = val;
        e.dir = d;
        sbq.push_back(e);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   t0;
        v   = vec[idx];
        ctx = $sformatf("vec%0d", idx);
        clear_mon();
        for (int i = 0; i < int'(v.n); i++) push_exp(exp_tab[idx][i], v.dirs[i]);
        gap_chk  = int'(v.gap);
        sync_chk = (v.sync != 0);
        wrap_en  = sync_chk;
        drive_cfg(v);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        t0 = cyc;
        check("busy_after_start", 32'(busy_o), 32'd1);
        for (int k = 0; k < 300; k++) begin
            if (v.term != 0 && done_cnt > 0) break;
            if (v.term == 0 && pulses >= int'(v.n)) break;
            tick();
        end
        check("pulse_count", 32'(pulses), v.n);
        check("first_latency", 32'(first_pc - t0), 32'd1);
        if (v.term != 0) begin
            check("done_seen", 32'(done_cnt), 32'd1);
            check("done_gap", 32'(done_cyc - last_pc), v.done_gap);
            check("busy_at_done", 32'(busy_o), 32'd0);
            repeat (3) tick();
            check("done_once", 32'(done_cnt), 32'd1);
            check("inc_hold", inc_o, exp_tab[idx][v.n-1]);
        end else begin
            abort_i = 1'b1;
            tick();
            abort_i = 1'b0;
            check("abort_inc", inc_o, 32'd0);
            check("abort_busy", 32'(busy_o), 32'd0);
            check("abort_dir", 32'(dir_o), 32'd0);
            check("no_done", 32'(done_cnt), 32'd0);
        end
        check("no_cfg_err", 32'(err_cnt), 32'd0);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        wrap_en  = 1'b0;
        sync_chk = 1'b0;
        gap_chk  = 0;
        tick();
    endtask

    initial begin
        vec[0] = '{0, 100, 130, 10, 3, 0, 4, 0, 1, 3, 3};
        vec[1] = '{0, 100, 125, 10, 3, 0, 4, 0, 1, 3, 3};
        vec[2] = '{2, 100, 130, 10, 2, 0, 9, 'h70, 0, 0, 2};
        vec[3] = '{1, 100, 130, 10, 2, 1, 6, 0, 0, 0, 0};
        vec[4] = '{0, 5, 7, 1, 0, 0, 3, 0, 1, 1, 1};
        vec[5] = '{0, 50, 50, 3, 4, 0, 1, 0, 1, 4, 0};
        vec[6] = '{0, 'hFFFF_FFF0, 'hFFFF_FFFF, 'h10, 1, 0, 2, 0, 1, 1, 1};
        vec[7] = '{3, 'h0002_9F17, 0, 0, 5, 0, 1, 0, 1, 0, 0};
        exp_tab[0] = '{100, 110, 120, 130, 0, 0, 0, 0, 0, 0};
        exp_tab[1] = '{100, 110, 120, 125, 0, 0, 0, 0, 0, 0};
        exp_tab[2] = '{100, 110, 120, 130, 120, 110, 100, 110, 120, 0};
        exp_tab[3] = '{100, 110, 120, 130, 100, 110, 0, 0, 0, 0};
        exp_tab[4] = '{5, 6, 7, 0, 0, 0, 0, 0, 0, 0};
        exp_tab[5] = '{50, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_tab[6] = '{'hFFFF_FFF0, 'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_tab[7] = '{'h0002_9F17, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        clear_mon();
        #12 rst = 1'b0;
        tick();
        ctx = "reset";
        check("inc", inc_o, 32'd0);
        check("inc_valid", 32'(inc_valid_o), 32'd0);
        check("busy", 32'(busy_o), 32'd0);
        check("done", 32'(done_o), 32'd0);
        check("dir", 32'(dir_o), 32'd0);
        check("cfg_err", 32'(cfg_err_o), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Abort while idle clears the held fixed tone
        ctx = "idle_abort";
        check("held_tone", inc_o, 32'h0002_9F17);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("inc", inc_o, 32'd0);
        check("busy", 32'(busy_o), 32'd0);

        // Rejected starts
        ctx = "cfg_err";
        clear_mon();
        drive_cfg('{0, 100, 130, 0, 3, 0, 0, 0, 0, 0, 0});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("step0_err", 32'(cfg_err_o), 32'd1);
        check("step0_busy", 32'(busy_o), 32'd0);
        tick();
        check("err_one_cycle", 32'(cfg_err_o), 32'd0);
        drive_cfg('{1, 200, 100, 5, 3, 0, 0, 0, 0, 0, 0});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("order_err", 32'(cfg_err_o), 32'd1);
        tick();
        check("order_busy", 32'(busy_o), 32'd0);
        check("no_pulses", 32'(pulses), 32'd0);

        // Abort during the dwell of 120; a start while busy is ignored
        ctx = "abort_dwell";
        clear_mon();
        push_exp(100, 1'b0);
        push_exp(110, 1'b0);
        push_exp(120, 1'b0);
        drive_cfg(vec[0]);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        mode_i      = 2'b11;
        start_inc_i = 32'd999;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 50 && pulses < 3; k++) tick();
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("inc", inc_o, 32'd0);
        check("busy", 32'(busy_o), 32'd0);
        repeat (6) tick();
        check("pulses", 32'(pulses), 32'd3);
        check("no_done", 32'(done_cnt), 32'd0);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        // Degenerate triangle: dir toggles, inc constant
        ctx = "tri_flat";
        clear_mon();
        push_exp(40, 1'b0);
        drive_cfg('{2, 40, 40, 5, 2, 0, 0, 0, 0, 0, 0});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("first_dir", 32'(dir_o), 32'd0);
        repeat (2) tick();
        check("dir_up", 32'(dir_o), 32'd1);
        check("inc_flat", inc_o, 32'd40);
        repeat (2) tick();
        check("dir_down", 32'(dir_o), 32'd0);
        check("one_pulse", 32'(pulses), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;

        // Asynchronous reset mid-sweep
        ctx = "async_rst";
        clear_mon();
        push_exp(100, 1'b0);
        push_exp(110, 1'b0);
        push_exp(120, 1'b0);
        push_exp(130, 1'b0);
        drive_cfg(vec[0]);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 50 && pulses < 2; k++) tick();
        #3 rst = 1'b1;
        #1;
        check("inc", inc_o, 32'd0);
        check("busy", 32'(busy_o), 32'd0);
        check("inc_valid", 32'(inc_valid_o), 32'd0);
        check("dir", 32'(dir_o), 32'd0);
        #2 rst = 1'b0;
        sbq.delete();
        repeat (3) tick();
        check("idle_after", 32'(busy_o), 32'd0);
        check("inc_after", inc_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
